// File: rtl/preg_free_list.sv
// Circular free list of physical register tags for a 2-wide rename stage, with a
// speculative head for allocation and a retired head that a flush rolls back to.
module preg_free_list #(
  parameter int NUM_P_REGS = 64,
  parameter int NUM_A_REGS = 32,
  localparam int PW = $clog2(NUM_P_REGS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          alloc0_req_i,
  input  logic          alloc1_req_i,
  output logic [PW-1:0] alloc0_preg_o,
  output logic [PW-1:0] alloc1_preg_o,
  output logic          stall_o,
  input  logic [1:0]    commit_cnt_i,
  input  logic          free0_valid_i,
  input  logic [PW-1:0] free0_preg_i,
  input  logic          free1_valid_i,
  input  logic [PW-1:0] free1_preg_i,
  input  logic          recover_i,
  output logic [PW:0]   free_count_o,
  output logic          err_o
);

  localparam logic [PW:0] DEPTH      = (PW+1)'(NUM_P_REGS);
  localparam logic [PW:0] TAIL_RESET = (PW+1)'(NUM_P_REGS - NUM_A_REGS);

  logic [PW-1:0] mem [NUM_P_REGS];
  logic [PW:0]   spec_head;
  logic [PW:0]   ret_head;
  logic [PW:0]   tail;

  logic [1:0]    nreq;
  logic [PW:0]   nreq_ext;
  logic [PW:0]   cc_ext;
  logic [PW:0]   head1;
  logic [PW:0]   outstanding;
  logic [PW:0]   occ0;
  logic [PW:0]   occ1;
  logic [PW:0]   tail1;
  logic [PW:0]   ret_next;
  logic          commit_err;
  logic          f0_ok, f1_ok;
  logic          f0_ovf, f1_ovf;
  logic          f0_acc, f1_acc;

  always_comb begin
    nreq          = {1'b0, alloc0_req_i} + {1'b0, alloc1_req_i};
    nreq_ext      = {{(PW-1){1'b0}}, nreq};
    cc_ext        = {{(PW-1){1'b0}}, commit_cnt_i};
    free_count_o  = tail - spec_head;
    stall_o       = recover_i | (nreq_ext > free_count_o);
    head1         = spec_head + {{PW{1'b0}}, alloc0_req_i};
    alloc0_preg_o = mem[spec_head[PW-1:0]];
    alloc1_preg_o = mem[head1[PW-1:0]];

    // Commits may only retire what has actually been handed out.
    outstanding   = spec_head - ret_head;
    commit_err    = cc_ext > outstanding;
    ret_next      = commit_err ? ret_head : ret_head + cc_ext;

    // Tag 0 is silently discarded; other frees are dropped only if the ring is full.
    occ0          = tail - ret_head;
    f0_ok         = free0_valid_i && (free0_preg_i != '0);
    f0_ovf        = f0_ok && (occ0 >= DEPTH);
    f0_acc        = f0_ok && !f0_ovf;
    occ1          = occ0 + {{PW{1'b0}}, f0_acc};
    f1_ok         = free1_valid_i && (free1_preg_i != '0);
    f1_ovf        = f1_ok && (occ1 >= DEPTH);
    f1_acc        = f1_ok && !f1_ovf;
    tail1         = tail + {{PW{1'b0}}, f0_acc};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spec_head <= '0;
      ret_head  <= '0;
      tail      <= TAIL_RESET;
      err_o     <= 1'b0;
    end else begin
      if (recover_i)
        spec_head <= ret_next;
      else if (!stall_o)
        spec_head <= spec_head + nreq_ext;
      ret_head <= ret_next;
      tail     <= tail1 + {{PW{1'b0}}, f1_acc};
      if (commit_err || f0_ovf || f1_ovf)
        err_o <= 1'b1;
    end
  end

  // Entries beyond the initial free tags start at zero; they are always
  // written by a free before the speculative head can reach them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_P_REGS; i++)
        mem[i] <= (i < NUM_P_REGS - NUM_A_REGS) ? PW'(NUM_A_REGS + i) : '0;
    end else begin
      if (f0_acc)
        mem[tail[PW-1:0]] <= free0_preg_i;
      if (f1_acc)
        mem[tail1[PW-1:0]] <= free1_preg_i;
    end
  end

endmodule

// File: tb/tb_preg_free_list.sv
// Directed table-driven bench for preg_free_list: each record sets one cycle of
// inputs and the combinational outputs expected before that cycle's clock edge.
module tb_preg_free_list;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       alloc0_req_i, alloc1_req_i;
  logic [5:0] alloc0_preg_o, alloc1_preg_o;
  logic       stall_o;
  logic [1:0] commit_cnt_i;
  logic       free0_valid_i, free1_valid_i;
  logic [5:0] free0_preg_i, free1_preg_i;
  logic       recover_i;
  logic [6:0] free_count_o;
  logic       err_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  preg_free_list #(.NUM_P_REGS(64), .NUM_A_REGS(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alloc0_req_i(alloc0_req_i), .alloc1_req_i(alloc1_req_i),
    .alloc0_preg_o(alloc0_preg_o), .alloc1_preg_o(alloc1_preg_o),
    .stall_o(stall_o), .commit_cnt_i(commit_cnt_i),
    .free0_valid_i(free0_valid_i), .free0_preg_i(free0_preg_i),
    .free1_valid_i(free1_valid_i), .free1_preg_i(free1_preg_i),
    .recover_i(recover_i), .free_count_o(free_count_o), .err_o(err_o)
  );

  typedef struct {
    string      name;
    logic       a0, a1, rec;
    logic [1:0] cc;
    logic       f0v;
    logic [5:0] f0;
    logic       f1v;
    logic [5:0] f1;
    logic       chk_p0, chk_p1;
    int         e_p0, e_p1;
    logic       e_stall;
    int         e_cnt;
    logic       e_err;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic a0, input logic a1, input logic rec, input logic [1:0] cc,
                       input logic f0v, input logic [5:0] f0, input logic f1v, input logic [5:0] f1);
    alloc0_req_i  = a0;
    alloc1_req_i  = a1;
    recover_i     = rec;
    commit_cnt_i  = cc;
    free0_valid_i = f0v;
    free0_preg_i  = f0;
    free1_valid_i = f1v;
    free1_preg_i  = f1;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk_i);
    drive(v.a0, v.a1, v.rec, v.cc, v.f0v, v.f0, v.f1v, v.f1);
    #1;
    if (v.chk_p0) check({v.name, ".p0"}, int'(alloc0_preg_o), v.e_p0);
    if (v.chk_p1) check({v.name, ".p1"}, int'(alloc1_preg_o), v.e_p1);
    check({v.name, ".stall"}, int'(stall_o), int'(v.e_stall));
    check({v.name, ".count"}, int'(free_count_o), v.e_cnt);
    check({v.name, ".err"}, int'(err_o), int'(v.e_err));
  endtask

  vec_t ta [7];
  vec_t tb [11];
  int   sh;

  initial begin
    //        name      a0 a1 rec cc f0v f0 f1v f1 cp0 cp1 p0  p1  stall cnt err
    ta[0] = '{"reset",  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32, 32, 0, 32, 0};
    ta[1] = '{"dual",   1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 32, 33, 0, 32, 0};
    ta[2] = '{"after2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 34, 34, 0, 30, 0};
    ta[3] = '{"slot1",  0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 34, 34, 0, 30, 0};
    ta[4] = '{"after1", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 35, 35, 0, 29, 0};
    ta[5] = '{"recov",  1, 0, 1, 2, 0, 0, 0, 0, 1, 1, 35, 36, 1, 29, 0};
    ta[6] = '{"rolled", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 34, 34, 0, 30, 0};

    tb[0]  = '{"full2",  1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 63,  0, 1,  1, 0};
    tb[1]  = '{"last1",  1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 63,  0, 0,  1, 0};
    tb[2]  = '{"empfre", 1, 0, 0, 0, 1, 5, 1, 7, 0, 0,  0,  0, 1,  0, 0};
    tb[3]  = '{"got5",   1, 0, 0, 0, 0, 0, 0, 0, 1, 1,  5,  7, 0,  2, 0};
    tb[4]  = '{"got7",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0,  7,  0, 0,  1, 0};
    tb[5]  = '{"free0",  0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  0,  0, 0,  0, 0};
    tb[6]  = '{"nofree", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0,  0, 0};
    tb[7]  = '{"flush",  0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0,  0, 1,  0, 0};
    tb[8]  = '{"badcmt", 0, 0, 0, 2, 0, 0, 0, 0, 1, 1, 34, 34, 0, 32, 0};
    tb[9]  = '{"errset", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 34, 34, 0, 32, 1};
    tb[10] = '{"errstk", 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 34, 34, 0, 32, 1};

    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    foreach (ta[i]) apply(ta[i]);

    // Drain from 30 free entries down to 1 with in-order tags.
    sh = 2;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk_i);
      drive(1, (k < 14) ? 1'b1 : 1'b0, 0, 0, 0, 0, 0, 0);
      #1;
      check("drain.p0", int'(alloc0_preg_o), 32 + sh);
      if (k < 14) check("drain.p1", int'(alloc1_preg_o), 33 + sh);
      check("drain.count", int'(free_count_o), 32 - sh);
      check("drain.stall", int'(stall_o), 0);
      sh += (k < 14) ? 2 : 1;
    end

    foreach (tb[i]) apply(tb[i]);

    // Reset clears the sticky error and restores the initial list.
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rst.err", int'(err_o), 0);
    check("rst.count", int'(free_count_o), 32);
    check("rst.p0", int'(alloc0_preg_o), 32);
    check("rst.stall", int'(stall_o), 0);

    @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
